// File: rtl/snd_i2s_pkg.sv
// Shared constants and types for the I2S serial data port.
package snd_i2s_pkg;

  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam logic        LR_LEFT    = 1'b0;

  // Bit position inside a 32-bit slot; 0 is the LRCLK-change bit.
  typedef logic [4:0] pos_t;

  // Slot position advance, saturating at the last slot bit.
  function automatic pos_t pos_inc_sat(input pos_t p);
    return (p == pos_t'(SLOT_BITS - 1)) ? p : p + pos_t'(1);
  endfunction

endpackage

// File: rtl/snd_i2s_edge.sv
// BCLK edge detection, LRCLK change detection, slot position and sync state.
module snd_i2s_edge
  import snd_i2s_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bclk,
  input  logic lrclk,
  output logic bclk_rise,
  output logic bclk_fall,
  output logic lr_chg,
  output pos_t pos_next,
  output pos_t pos_q,
  output logic lr_q,
  output logic synced_q
);

  logic bclk_q, bclk_d;
  logic lr_d;
  logic synced_d;
  pos_t pos_d;

  // Edge/change detect and next position, evaluated on every CLK.
  always_comb begin
    bclk_rise = bclk & ~bclk_q;
    bclk_fall = ~bclk & bclk_q;
    lr_chg    = bclk_rise & (lrclk != lr_q);
    bclk_d    = bclk;
    lr_d      = lr_q;
    pos_d     = pos_q;
    synced_d  = synced_q;
    if (bclk_rise) begin
      lr_d = lrclk;
      if (lr_chg) begin
        pos_d    = '0;
        synced_d = 1'b1;
      end else begin
        pos_d = pos_inc_sat(pos_q);
      end
    end
    pos_next = pos_d;
  end

  // Edge-detect and slot-position state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_q   <= 1'b1;
      lr_q     <= 1'b0;
      pos_q    <= '0;
      synced_q <= 1'b0;
    end else begin
      bclk_q   <= bclk_d;
      lr_q     <= lr_d;
      pos_q    <= pos_d;
      synced_q <= synced_d;
    end
  end

endmodule

// File: rtl/snd_i2s_port.sv
// I2S serial data port: ADC deserializer and DAC serializer with valid/ready handshakes.
module snd_i2s_port
  import snd_i2s_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         SND_BCLK,
  input  logic         SND_LRCLK,
  input  logic         SND_ADCDAT,
  output logic         SND_DACDAT,
  output logic [W-1:0] RX_L,
  output logic [W-1:0] RX_R,
  output logic         RX_VALID,
  input  logic         RX_READY,
  input  logic [W-1:0] TX_L,
  input  logic [W-1:0] TX_R,
  input  logic         TX_VALID,
  output logic         TX_READY,
  output logic         RX_OVERRUN,
  output logic         TX_UNDERRUN,
  input  logic         ERR_CLR
);

  localparam pos_t POS_W = pos_t'(W);

  logic rise, fall, chg, lr_q, synced_q;
  pos_t pos_next, pos_q;

  snd_i2s_edge u_edge (
    .clk      (CLK),
    .rst      (RST),
    .bclk     (SND_BCLK),
    .lrclk    (SND_LRCLK),
    .bclk_rise(rise),
    .bclk_fall(fall),
    .lr_chg   (chg),
    .pos_next (pos_next),
    .pos_q    (pos_q),
    .lr_q     (lr_q),
    .synced_q (synced_q)
  );

  logic         dac_q, dac_d;
  logic [W-1:0] rx_sh_q, rx_sh_d, rx_lw_q, rx_lw_d;
  logic         lvalid_q, lvalid_d;
  logic [W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic         rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic [W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic         tx_ready_q, tx_ready_d, tx_und_q, tx_und_d;
  logic [W-1:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d;

  logic [W:0]   sh_ext;
  logic [W-1:0] sh_shift, tx_word, tx_shifted;
  logic         take, word_end, complete, ovr_set, und_set, tx_load;

  // RX shift/latch/handshake, TX holding/frame load, and DAC bit selection.
  always_comb begin
    rx_sh_d    = rx_sh_q;
    rx_lw_d    = rx_lw_q;
    lvalid_d   = lvalid_q;
    rx_l_d     = rx_l_q;
    rx_r_d     = rx_r_q;
    rx_valid_d = rx_valid_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    tx_ready_d = tx_ready_q;
    frm_l_d    = frm_l_q;
    frm_r_d    = frm_r_q;
    dac_d      = dac_q;
    ovr_set    = 1'b0;
    und_set    = 1'b0;

    sh_ext   = {rx_sh_q, SND_ADCDAT};
    sh_shift = sh_ext[W-1:0];
    take     = rise & synced_q & (pos_next != '0) & (pos_next <= POS_W);
    word_end = take & (pos_next == POS_W);
    complete = word_end & (SND_LRCLK != LR_LEFT) & lvalid_q;

    if (take) rx_sh_d = sh_shift;
    if (chg && (SND_LRCLK == LR_LEFT)) lvalid_d = 1'b0;
    if (word_end && (SND_LRCLK == LR_LEFT)) begin
      rx_lw_d  = sh_shift;
      lvalid_d = 1'b1;
    end
    if (complete) lvalid_d = 1'b0;

    // A completing pair may replace the held one only if it leaves this cycle.
    if (complete) begin
      if (!rx_valid_q || RX_READY) begin
        rx_l_d     = rx_lw_q;
        rx_r_d     = sh_shift;
        rx_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rx_valid_q && RX_READY) begin
      rx_valid_d = 1'b0;
    end
    rx_ovr_d = ovr_set ? 1'b1 : (ERR_CLR ? 1'b0 : rx_ovr_q);

    tx_load = chg & (SND_LRCLK == LR_LEFT);
    if (tx_load) begin
      if (!tx_ready_q) begin
        frm_l_d    = hold_l_q;
        frm_r_d    = hold_r_q;
        tx_ready_d = 1'b1;
      end else begin
        frm_l_d = '0;
        frm_r_d = '0;
        und_set = 1'b1;
      end
    end
    if (TX_VALID && tx_ready_q) begin
      hold_l_d   = TX_L;
      hold_r_d   = TX_R;
      tx_ready_d = 1'b0;
    end
    tx_und_d = und_set ? 1'b1 : (ERR_CLR ? 1'b0 : tx_und_q);

    // Bit driven at a fall is the one sampled at the following rise (pos_q + 1).
    tx_word    = lr_q ? frm_r_q : frm_l_q;
    tx_shifted = tx_word >> (POS_W - pos_t'(1) - pos_q);
    if (fall) dac_d = synced_q & (pos_q < POS_W) & tx_shifted[0];
  end

  // Datapath and handshake registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dac_q      <= 1'b0;
      rx_sh_q    <= '0;
      rx_lw_q    <= '0;
      lvalid_q   <= 1'b0;
      rx_l_q     <= '0;
      rx_r_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      tx_ready_q <= 1'b1;
      tx_und_q   <= 1'b0;
      frm_l_q    <= '0;
      frm_r_q    <= '0;
    end else begin
      dac_q      <= dac_d;
      rx_sh_q    <= rx_sh_d;
      rx_lw_q    <= rx_lw_d;
      lvalid_q   <= lvalid_d;
      rx_l_q     <= rx_l_d;
      rx_r_q     <= rx_r_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      tx_ready_q <= tx_ready_d;
      tx_und_q   <= tx_und_d;
      frm_l_q    <= frm_l_d;
      frm_r_q    <= frm_r_d;
    end
  end

  assign SND_DACDAT  = dac_q;
  assign RX_L        = rx_l_q;
  assign RX_R        = rx_r_q;
  assign RX_VALID    = rx_valid_q;
  assign TX_READY    = tx_ready_q;
  assign RX_OVERRUN  = rx_ovr_q;
  assign TX_UNDERRUN = tx_und_q;

endmodule
